// File: rtl/mux16_scanner_pkg.sv
// rtl/mux16_scanner_pkg.sv - shared types and constants for the 16-channel scanner
// Contents:
//   N_CH, SEL_W  channel count and channel-index width
//   state_t      scanner FSM states (IDLE, SCAN, DONE)
//   lowest_set   {found, index} of the lowest set bit of a channel mask
package mux16_scanner_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // The MSB of the result is the found flag; the low bits are the index.
    // Scanning from the top down lets the lowest set bit win.
    function automatic logic [SEL_W:0] lowest_set(input logic [N_CH-1:0] m);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux16_next_idx.sv
// rtl/mux16_next_idx.sv - combinational search for the next enabled channel
// Ports:
//   i_mask_q    captured channel-enable mask
//   i_cur_idx   channel index currently on the serial output
//   o_next_idx  lowest enabled index strictly greater than i_cur_idx
//   o_found     1 when such an index exists
module mux16_next_idx
    import mux16_scanner_pkg::*;
(
    input  logic [N_CH-1:0]  i_mask_q,
    input  logic [SEL_W-1:0] i_cur_idx,
    output logic [SEL_W-1:0] o_next_idx,
    output logic             o_found
);

    always_comb begin
        o_next_idx = '0;
        o_found    = 1'b0;
        // Descending loop: the last hit written is the lowest qualifying index.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask_q[i] && (i > int'(i_cur_idx))) begin
                o_found    = 1'b1;
                o_next_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux16_scanner.sv
// rtl/mux16_scanner.sv - captures 16 channel bits and serialises the enabled ones
// Parameter:
//   SKIP_MASKED  1: visit only channels enabled in mask; 0: visit all 16 channels
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   start        capture din/mask and begin a scan (honoured only in IDLE)
//   din, mask    parallel channel data and channel enables
//   ready        downstream accepts the current beat
//   dout, sel    serial data bit and its channel index
//   valid        dout/sel carry a beat
//   busy         FSM is not in IDLE
//   done         one-cycle pulse at the end of each scan
module mux16_scanner
    import mux16_scanner_pkg::*;
#(
    parameter bit SKIP_MASKED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  din,
    input  logic [N_CH-1:0]  mask,
    input  logic             ready,
    output logic             dout,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    logic [N_CH-1:0]    r_data_q;
    logic [N_CH-1:0]    r_mask_q;
    logic [SEL_W-1:0]   r_sel;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               w_capture;
    logic [N_CH-1:0]    w_mask_in;
    logic [SEL_W:0]     w_first;
    logic [SEL_W-1:0]   w_next_idx;
    logic               w_next_found;

    // With SKIP_MASKED cleared every channel is treated as enabled.
    assign w_mask_in = SKIP_MASKED ? mask : {N_CH{1'b1}};

    // The first beat must be on sel the cycle after start, so the initial
    // index is found from the incoming mask rather than from r_mask_q.
    assign w_first = lowest_set(w_mask_in);

    mux16_next_idx u_next_idx (
        .i_mask_q   (r_mask_q),
        .i_cur_idx  (r_sel),
        .o_next_idx (w_next_idx),
        .o_found    (w_next_found)
    );

    // dout depends only on registers, so ready never reaches valid/dout
    // combinationally.
    assign dout = r_data_q[r_sel];
    assign sel  = r_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_capture   = 1'b0;
        valid       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_capture = 1'b1;
                    if (w_first[SEL_W]) begin
                        w_state_nxt = SCAN;
                        w_sel_nxt   = w_first[SEL_W-1:0];
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SCAN: begin
                valid = 1'b1;
                if (ready) begin
                    if (w_next_found) begin
                        w_sel_nxt = w_next_idx;
                    end else begin
                        // No wrap-around: the scan ends after the highest
                        // enabled channel.
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_data_q <= '0;
            r_mask_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            if (w_capture) begin
                r_data_q <= din;
                r_mask_q <= w_mask_in;
            end
        end
    end

endmodule

// File: tb/tb_mux16_scanner.sv
// tb/tb_mux16_scanner.sv - randomized self-checking bench for mux16_scanner
module tb_mux16_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_m;
    logic        start_a;
    logic        ready;
    logic [15:0] din;
    logic [15:0] mask;

    logic        dout_m, valid_m, busy_m, done_m;
    logic [3:0]  sel_m;
    logic        dout_a, valid_a, busy_a, done_a;
    logic [3:0]  sel_a;

    bit          which;
    logic        o_dout, o_valid, o_busy, o_done;
    logic [3:0]  o_sel;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux16_scanner #(.SKIP_MASKED(1'b1)) u_dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_m),
        .din   (din),
        .mask  (mask),
        .ready (ready),
        .dout  (dout_m),
        .sel   (sel_m),
        .valid (valid_m),
        .busy  (busy_m),
        .done  (done_m)
    );

    mux16_scanner #(.SKIP_MASKED(1'b0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .din   (din),
        .mask  (mask),
        .ready (ready),
        .dout  (dout_a),
        .sel   (sel_a),
        .valid (valid_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    always_comb begin
        o_dout  = which ? dout_m  : dout_a;
        o_sel   = which ? sel_m   : sel_a;
        o_valid = which ? valid_m : valid_a;
        o_busy  = which ? busy_m  : busy_a;
        o_done  = which ? done_m  : done_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit v);
        if (which) start_m = v;
        else       start_a = v;
    endtask

    // Reference: a scan emits, in ascending order, one beat per enabled
    // channel carrying that channel's captured data bit, then one done cycle.
    task automatic run_scan(input bit w, input logic [15:0] d, input logic [15:0] m,
                            input int stall_pct, input int stall_first, input bit noise);
        logic [15:0] eff;
        int          exp_sel[$];
        bit          exp_bit[$];
        int          idx;
        int          held;
        int          guard;
        bit          rdy;
        which = w;
        eff   = w ? m : 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (eff[i]) begin
                exp_sel.push_back(i);
                exp_bit.push_back(d[i]);
            end
        end
        @(negedge clk);
        check("idle_before_start", o_busy, 1'b0);
        din  = d;
        mask = m;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        din  = 16'($urandom);
        mask = 16'($urandom);
        check("busy_after_start", o_busy, 1'b1);
        idx   = 0;
        held  = 0;
        guard = 0;
        while (idx < exp_sel.size() && guard < 1000) begin
            check("valid", o_valid, 1'b1);
            check("sel", o_sel, exp_sel[idx]);
            check("dout", o_dout, exp_bit[idx]);
            check("done_in_scan", o_done, 1'b0);
            if (idx == 0 && held < stall_first) begin
                rdy = 1'b0;
                held++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            ready = rdy;
            if (noise) set_start(1'($urandom_range(1)));
            if (rdy) idx++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 1000) check("scan_timeout", guard, 0);
        check("done_pulse", o_done, 1'b1);
        check("valid_in_done", o_valid, 1'b0);
        check("busy_in_done", o_busy, 1'b1);
        ready = 1'($urandom_range(1));
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("done_one_cycle", o_done, 1'b0);
        check("busy_idle", o_busy, 1'b0);
        check("valid_idle", o_valid, 1'b0);
        @(negedge clk);
        check("start_on_done_ignored", o_busy, 1'b0);
    endtask

    task automatic reset_mid_scan();
        int guard;
        which = 1'b1;
        @(negedge clk);
        din     = 16'hFFFF;
        mask    = 16'hFFFF;
        ready   = 1'b1;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        guard   = 0;
        while (!(o_valid && o_sel == 4'd7) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("reached_sel7", (o_valid && o_sel == 4'd7), 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_sel", o_sel, 4'd0);
        check("rst_dout", o_dout, 1'b0);
        check("rst_done", o_done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_done", o_done, 1'b0);
            check("post_rst_busy", o_busy, 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_m = 1'b0;
        start_a = 1'b0;
        ready   = 1'b0;
        din     = 16'hFFFF;
        mask    = 16'hFFFF;
        which   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid_m", valid_m, 1'b0);
        check("reset_busy_m", busy_m, 1'b0);
        check("reset_done_m", done_m, 1'b0);
        check("reset_sel_m", sel_m, 4'd0);
        check("reset_dout_m", dout_m, 1'b0);
        check("reset_valid_a", valid_a, 1'b0);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_sel_a", sel_a, 4'd0);
        rst_n = 1'b1;

        run_scan(1'b1, 16'hA5C3, 16'hFFFF, 0, 0, 1'b0);
        run_scan(1'b1, 16'hFFFF, 16'h8421, 0, 0, 1'b0);
        run_scan(1'b1, 16'($urandom), 16'h0000, 0, 0, 1'b0);
        run_scan(1'b1, 16'h0001, 16'h0003, 0, 3, 1'b0);
        reset_mid_scan();
        run_scan(1'b1, 16'($urandom), 16'h0F80, 20, 0, 1'b1);
        run_scan(1'b0, 16'hA5C3, 16'h0000, 30, 0, 1'b1);
        run_scan(1'b0, 16'($urandom), 16'($urandom), 30, 0, 1'b1);
        run_scan(1'b1, 16'($urandom), 16'h8000, 30, 0, 1'b1);
        run_scan(1'b1, 16'($urandom), 16'h0001, 30, 0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            run_scan(1'($urandom_range(1)), 16'($urandom),
                     16'($urandom & $urandom), 30, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
